// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit
// Write-side initiator for the register file. ALU results and buffered load
// results share one registered write port; a per-register busy scoreboard
// drives the decode stall.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   issue_valid/issue_addr            destination issued this cycle (sets busy)
//   alu_valid/alu_addr/alu_data       ALU result (highest write priority)
//   ld_valid/ld_addr/ld_data/ld_ready load result offer into the in-order queue
//   rdReg_addr1/2, rd_use1/2          decode operand reads, used for stall
//   stall                             hold decode this cycle
//   sig_regWrite/wrReg_addr/wr_data   registered register-file write port
//   busy                              scoreboard, bit i = register i pending
//   lq_count                          load queue occupancy
//   ld_overflow                       sticky: load offered while queue full
module regfile_writeback_unit #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned NREG     = 8,
   parameter int unsigned LQ_DEPTH = 2,
   localparam int unsigned CNT_W   = $clog2(LQ_DEPTH + 1),
   localparam int unsigned PTR_W   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] rdReg_addr1,
   input  logic [ADDR_W-1:0] rdReg_addr2,
   input  logic              rd_use1,
   input  logic              rd_use2,
   output logic              stall,
   output logic              sig_regWrite,
   output logic [ADDR_W-1:0] wrReg_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [NREG-1:0]   busy,
   output logic [CNT_W-1:0]  lq_count,
   output logic              ld_overflow
);

   localparam logic [CNT_W-1:0] LqFull = CNT_W'(LQ_DEPTH);

   // Load queue storage and pointers
   logic [ADDR_W-1:0] lq_addr_q [LQ_DEPTH];
   logic [ADDR_W-1:0] lq_addr_d [LQ_DEPTH];
   logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];
   logic [DATA_W-1:0] lq_data_d [LQ_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;

   // Write port and scoreboard
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [NREG-1:0]   busy_q, busy_d;

   logic push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(LQ_DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign ld_ready = (count_q < LqFull);
   // Pop decision uses pre-push occupancy: no same-cycle pass-through.
   assign push     = ld_valid && ld_ready;
   assign pop      = !alu_valid && (count_q != '0);

   always_comb begin
      lq_addr_d = lq_addr_q;
      lq_data_d = lq_data_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;

      if (push) begin
         lq_addr_d[wr_ptr_q] = ld_addr;
         lq_data_d[wr_ptr_q] = ld_data;
         wr_ptr_d            = ptr_inc(wr_ptr_q);
      end
      if (ld_valid && !ld_ready) begin
         ovf_d = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (alu_valid) begin
         we_d    = 1'b1;
         waddr_d = alu_addr;
         wdata_d = alu_data;
      end else if (pop) begin
         we_d    = 1'b1;
         waddr_d = lq_addr_q[rd_ptr_q];
         wdata_d = lq_data_q[rd_ptr_q];
      end

      // Clear first so a same-edge issue (newer producer) wins.
      if (we_d) begin
         busy_d[waddr_d] = 1'b0;
      end
      if (issue_valid) begin
         busy_d[issue_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(LQ_DEPTH); i++) begin
            lq_addr_q[i] <= '0;
            lq_data_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         busy_q   <= '0;
      end else begin
         lq_addr_q <= lq_addr_d;
         lq_data_q <= lq_data_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
      end
   end

   // The register file holds its read outputs during a write cycle, so any
   // operand read collides with an active write.
   assign stall = (rd_use1 && busy_q[rdReg_addr1]) ||
                  (rd_use2 && busy_q[rdReg_addr2]) ||
                  (we_q && (rd_use1 || rd_use2));

   assign sig_regWrite = we_q;
   assign wrReg_addr   = waddr_q;
   assign wr_data      = wdata_q;
   assign busy         = busy_q;
   assign lq_count     = count_q;
   assign ld_overflow  = ovf_q;

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit: directed steps followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_regfile_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [2:0]  issue_addr;
   logic        alu_valid;
   logic [2:0]  alu_addr;
   logic [15:0] alu_data;
   logic        ld_valid;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic        ld_ready;
   logic [2:0]  rdReg_addr1, rdReg_addr2;
   logic        rd_use1, rd_use2;
   logic        stall;
   logic        sig_regWrite;
   logic [2:0]  wrReg_addr;
   logic [15:0] wr_data;
   logic [7:0]  busy;
   logic [1:0]  lq_count;
   logic        ld_overflow;

   regfile_writeback_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_addr   (issue_addr),
      .alu_valid    (alu_valid),
      .alu_addr     (alu_addr),
      .alu_data     (alu_data),
      .ld_valid     (ld_valid),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .ld_ready     (ld_ready),
      .rdReg_addr1  (rdReg_addr1),
      .rdReg_addr2  (rdReg_addr2),
      .rd_use1      (rd_use1),
      .rd_use2      (rd_use2),
      .stall        (stall),
      .sig_regWrite (sig_regWrite),
      .wrReg_addr   (wrReg_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .lq_count     (lq_count),
      .ld_overflow  (ld_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: pending loads as a queue of {addr, data}
   logic [18:0] m_q[$];
   logic [7:0]  m_busy;
   logic        m_we;
   logic [2:0]  m_wa;
   logic [15:0] m_wd;
   logic        m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_q.delete();
      m_busy = 8'h00;
      m_we   = 1'b0;
      m_wa   = 3'd0;
      m_wd   = 16'h0000;
      m_ovf  = 1'b0;
   endtask

   function automatic logic m_stall();
      return (rd_use1 && m_busy[rdReg_addr1]) || (rd_use2 && m_busy[rdReg_addr2]) ||
             (m_we && (rd_use1 || rd_use2));
   endfunction

   task automatic model_step();
      logic        ready;
      logic [18:0] e;
      ready = (m_q.size() < 2);
      if (alu_valid) begin
         m_we = 1'b1; m_wa = alu_addr; m_wd = alu_data;
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         m_we = 1'b1; m_wa = e[18:16]; m_wd = e[15:0];
      end else begin
         m_we = 1'b0;
      end
      if (ld_valid) begin
         if (ready) m_q.push_back({ld_addr, ld_data});
         else       m_ovf = 1'b1;
      end
      if (m_we) m_busy[m_wa] = 1'b0;
      if (issue_valid) m_busy[issue_addr] = 1'b1;
   endtask

   // One clock: check combinational outputs, advance model, check registered outputs.
   task automatic tick();
      #1;
      chk("ld_ready", ld_ready, (m_q.size() < 2));
      chk("stall", stall, m_stall());
      model_step();
      @(posedge clk);
      #1;
      chk("sig_regWrite", sig_regWrite, m_we);
      chk("wrReg_addr", wrReg_addr, m_wa);
      chk("wr_data", wr_data, m_wd);
      chk("busy", busy, m_busy);
      chk("lq_count", lq_count, m_q.size());
      chk("ld_overflow", ld_overflow, m_ovf);
   endtask

   task automatic idle();
      issue_valid = 0; issue_addr = 0;
      alu_valid = 0; alu_addr = 0; alu_data = 0;
      ld_valid = 0; ld_addr = 0; ld_data = 0;
      rdReg_addr1 = 0; rdReg_addr2 = 0; rd_use1 = 0; rd_use2 = 0;
   endtask

   initial begin
      // Reset values
      idle();
      rst_n = 1'b0;
      m_reset();
      #3;
      chk("rst_busy", busy, 8'h00);
      chk("rst_lq_count", lq_count, 0);
      chk("rst_we", sig_regWrite, 0);
      chk("rst_waddr", wrReg_addr, 0);
      chk("rst_wdata", wr_data, 0);
      chk("rst_ovf", ld_overflow, 0);
      chk("rst_ld_ready", ld_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU path: issue r3, write r3 two cycles later
      issue_valid = 1; issue_addr = 3'd3;
      tick();
      chk("alu_busy3_c1", busy[3], 1);
      idle();
      tick();
      chk("alu_busy3_c2", busy[3], 1);
      alu_valid = 1; alu_addr = 3'd3; alu_data = 16'h000E;
      tick();
      chk("alu_we", sig_regWrite, 1);
      chk("alu_waddr", wrReg_addr, 3);
      chk("alu_wdata", wr_data, 16'h000E);
      chk("alu_busy3_clr", busy[3], 0);

      // Collision: ALU wins, load follows one cycle later
      idle();
      alu_valid = 1; alu_addr = 3'd1; alu_data = 16'h0004;
      ld_valid = 1; ld_addr = 3'd2; ld_data = 16'h0040;
      tick();
      chk("col_waddr1", wrReg_addr, 1);
      chk("col_count1", lq_count, 1);
      idle();
      tick();
      chk("col_we2", sig_regWrite, 1);
      chk("col_waddr2", wrReg_addr, 2);
      chk("col_wdata2", wr_data, 16'h0040);
      chk("col_count0", lq_count, 0);
      tick();
      chk("col_idle_we", sig_regWrite, 0);
      chk("col_hold_data", wr_data, 16'h0040);

      // Queue full: ALU held 4 cycles, 3 loads offered
      for (int i = 0; i < 4; i++) begin
         idle();
         alu_valid = 1; alu_addr = 3'd7; alu_data = 16'(i + 1);
         if (i < 3) begin
            ld_valid = 1; ld_addr = 3'(4 + i); ld_data = 16'(16'h0044 + 16'(i) * 16'h0011);
         end
         if (i == 2) begin
            #1;
            chk("full_ld_ready", ld_ready, 0);
         end
         tick();
      end
      chk("full_ovf", ld_overflow, 1);
      chk("full_count", lq_count, 2);
      idle();
      tick();
      chk("drain1_addr", wrReg_addr, 4);
      chk("drain1_data", wr_data, 16'h0044);
      tick();
      chk("drain2_addr", wrReg_addr, 5);
      chk("drain2_data", wr_data, 16'h0055);
      chk("drain_count", lq_count, 0);

      // Two loads to one register land in arrival order
      ld_valid = 1; ld_addr = 3'd2; ld_data = 16'hAAAA;
      tick();
      ld_data = 16'hBBBB;
      tick();
      chk("order1_data", wr_data, 16'hAAAA);
      idle();
      tick();
      chk("order2_addr", wrReg_addr, 2);
      chk("order2_data", wr_data, 16'hBBBB);
      tick();

      // Stall
      issue_valid = 1; issue_addr = 3'd6;
      tick();
      idle();
      rdReg_addr1 = 3'd6; rd_use1 = 1;
      #1;
      chk("stall_busy", stall, 1);
      rd_use1 = 0;
      #1;
      chk("stall_unused", stall, 0);
      alu_valid = 1; alu_addr = 3'd6; alu_data = 16'h1234;
      tick();
      idle();
      rdReg_addr2 = 3'd0; rd_use2 = 1;
      #1;
      chk("stall_write", stall, 1);
      idle();

      // Same-edge issue and write to r5
      issue_valid = 1; issue_addr = 3'd5;
      alu_valid = 1; alu_addr = 3'd5; alu_data = 16'h5555;
      tick();
      chk("same_we", sig_regWrite, 1);
      chk("same_addr", wrReg_addr, 5);
      chk("same_busy5", busy[5], 1);

      // Mid-operation reset with a full queue and all registers busy
      for (int i = 0; i < 8; i++) begin
         idle();
         issue_valid = 1; issue_addr = 3'(i);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         idle();
         issue_valid = 1; issue_addr = 3'd0;
         alu_valid = 1; alu_addr = 3'd0; alu_data = 16'(16'h0900 + i);
         ld_valid = 1; ld_addr = 3'(1 + i); ld_data = 16'(16'h0A00 + i);
         tick();
      end
      chk("pre_rst_busy", busy, 8'hFF);
      chk("pre_rst_count", lq_count, 2);
      idle();
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("mid_rst_busy", busy, 8'h00);
      chk("mid_rst_count", lq_count, 0);
      chk("mid_rst_we", sig_regWrite, 0);
      chk("mid_rst_ovf", ld_overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ld_ready", ld_ready, 1);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_addr  = 3'($urandom_range(0, 7));
         alu_valid   = ($urandom_range(0, 9) < 4);
         alu_addr    = 3'($urandom_range(0, 7));
         alu_data    = 16'($urandom);
         ld_valid    = ($urandom_range(0, 9) < 4);
         ld_addr     = 3'($urandom_range(0, 7));
         ld_data     = 16'($urandom);
         rdReg_addr1 = 3'($urandom_range(0, 7));
         rdReg_addr2 = 3'($urandom_range(0, 7));
         rd_use1     = ($urandom_range(0, 1) == 1);
         rd_use2     = ($urandom_range(0, 1) == 1);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
